// File: rtl/imm_mode_prob_update.sv
// IMM mode-probability update: Markov prediction, likelihood weighting, normalisation.
// Latency: result presented N^2 + N*(FRAC_BITS+2) + 1 cycles after the accept edge.
// Backpressure: single transaction in flight; result held stable in S_OUT until out_ready.
module imm_mode_prob_update #(
    parameter int N_MODELS   = 3,
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_mu_prev [N_MODELS],
    input  logic [DATA_WIDTH-1:0] in_pi      [N_MODELS][N_MODELS],
    input  logic [DATA_WIDTH-1:0] in_lik     [N_MODELS],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_mu     [N_MODELS],
    output logic [DATA_WIDTH-1:0] out_cbar   [N_MODELS],
    output logic [DATA_WIDTH-1:0] out_norm,
    output logic                  out_degenerate
);

    localparam int AW = DATA_WIDTH + $clog2(N_MODELS);   // accumulator width
    localparam int RW = AW + 1;                          // divider remainder width
    localparam int PW = 2 * DATA_WIDTH;                  // full product width
    localparam int QW = FRAC_BITS + 1;                   // quotient bits (mu <= 1.0)
    localparam int IW = (N_MODELS > 1) ? $clog2(N_MODELS) : 1;
    localparam int CW = $clog2(FRAC_BITS + 1);

    typedef enum logic [2:0] {S_IDLE, S_PRED, S_WEIGHT, S_DIV, S_OUT} state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mu_prev_q [N_MODELS];
    logic [DATA_WIDTH-1:0] pi_q      [N_MODELS][N_MODELS];
    logic [DATA_WIDTH-1:0] lik_q     [N_MODELS];
    logic [DATA_WIDTH-1:0] cbar_q    [N_MODELS];
    logic [DATA_WIDTH-1:0] w_q       [N_MODELS];
    logic [DATA_WIDTH-1:0] mu_q      [N_MODELS];
    logic [DATA_WIDTH-1:0] res_mu_q  [N_MODELS];
    logic [DATA_WIDTH-1:0] res_cbar_q[N_MODELS];
    logic [DATA_WIDTH-1:0] res_norm_q;
    logic                  res_degen_q;
    logic [IW-1:0]         i_q, j_q;
    logic [AW-1:0]         acc_q, norm_q;
    logic [RW-1:0]         rem_q;
    logic [QW-2:0]         quo_q;
    logic [CW-1:0]         bit_q;
    logic                  div_load_q;

    logic [DATA_WIDTH-1:0] pred_term, weight_term, mu_fin;
    logic [AW-1:0]         acc_nxt, norm_nxt, rem_sub;
    logic [RW-1:0]         rem_shift;
    logic [QW-1:0]         quo_nxt;
    logic                  rem_ge;
    logic [IW-1:0]         j_inc;
    logic                  pred_last, weight_last, bit_last, div_done;

    // Fixed-point multiply keeping the integer-aligned word, saturating on overflow.
    function automatic logic [DATA_WIDTH-1:0] trunc_mul(input logic [DATA_WIDTH-1:0] a,
                                                         input logic [DATA_WIDTH-1:0] b);
        logic [PW-1:0] sh;
        sh = (PW'(a) * PW'(b)) >> FRAC_BITS;
        return (|sh[PW-1:DATA_WIDTH]) ? '1 : sh[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a,
                                              input logic [DATA_WIDTH-1:0] b);
        logic [AW:0] s;
        s = (AW+1)'(a) + (AW+1)'(b);
        return s[AW] ? '1 : s[AW-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat_dw(input logic [AW-1:0] x);
        return (|x[AW-1:DATA_WIDTH]) ? '1 : x[DATA_WIDTH-1:0];
    endfunction

    assign pred_last   = (i_q == IW'(N_MODELS - 1)) && (j_q == IW'(N_MODELS - 1));
    assign weight_last = (j_q == IW'(N_MODELS - 1));
    assign bit_last    = !div_load_q && (bit_q == CW'(FRAC_BITS));
    assign div_done    = bit_last && (j_q == IW'(N_MODELS - 1));

    // Datapath arithmetic: MAC term, weight term and one restoring-division step.
    always_comb begin
        pred_term   = trunc_mul(pi_q[i_q][j_q], mu_prev_q[i_q]);
        acc_nxt     = sat_add(acc_q, pred_term);
        weight_term = trunc_mul(lik_q[j_q], cbar_q[j_q]);
        norm_nxt    = sat_add(norm_q, weight_term);
        rem_ge      = (rem_q >= RW'(norm_q));
        rem_sub     = rem_ge ? AW'(rem_q - RW'(norm_q)) : rem_q[AW-1:0];
        rem_shift   = {rem_sub, 1'b0};
        quo_nxt     = {quo_q, rem_ge};
        // A zero normaliser falls back to the predicted probabilities.
        mu_fin      = (norm_q == '0) ? cbar_q[j_q] : DATA_WIDTH'(quo_nxt);
        j_inc       = j_q + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_PRED;
            end
            S_PRED:   if (pred_last)   state_d = S_WEIGHT;
            S_WEIGHT: if (weight_last) state_d = S_DIV;
            S_DIV:    if (div_done)    state_d = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath registers: capture, accumulate, divide, publish result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < N_MODELS; a++) begin
                mu_prev_q[a]  <= '0;
                lik_q[a]      <= '0;
                cbar_q[a]     <= '0;
                w_q[a]        <= '0;
                mu_q[a]       <= '0;
                res_mu_q[a]   <= '0;
                res_cbar_q[a] <= '0;
                for (int b = 0; b < N_MODELS; b++) pi_q[a][b] <= '0;
            end
            res_norm_q  <= '0;
            res_degen_q <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            norm_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            bit_q       <= '0;
            div_load_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    mu_prev_q <= in_mu_prev;
                    pi_q      <= in_pi;
                    lik_q     <= in_lik;
                    i_q       <= '0;
                    j_q       <= '0;
                    acc_q     <= '0;
                    norm_q    <= '0;
                end
                // j outer, i inner: column j of pi folds into cbar_j.
                S_PRED: begin
                    if (i_q == IW'(N_MODELS - 1)) begin
                        cbar_q[j_q] <= sat_dw(acc_nxt);
                        acc_q       <= '0;
                        i_q         <= '0;
                        j_q         <= weight_last ? '0 : j_inc;
                    end else begin
                        acc_q <= acc_nxt;
                        i_q   <= i_q + 1'b1;
                    end
                end
                S_WEIGHT: begin
                    w_q[j_q] <= weight_term;
                    norm_q   <= norm_nxt;
                    j_q      <= weight_last ? '0 : j_inc;
                    if (weight_last) begin
                        div_load_q <= 1'b1;
                        bit_q      <= '0;
                    end
                end
                // First model gets a dedicated load cycle; later models load on the
                // previous model's final quotient-bit cycle.
                S_DIV: begin
                    if (div_load_q) begin
                        rem_q      <= RW'(w_q[j_q]);
                        quo_q      <= '0;
                        bit_q      <= '0;
                        div_load_q <= 1'b0;
                    end else begin
                        rem_q <= rem_shift;
                        quo_q <= quo_nxt[QW-2:0];
                        if (bit_last) begin
                            mu_q[j_q] <= mu_fin;
                            bit_q     <= '0;
                            if (div_done) begin
                                j_q <= '0;
                                for (int k = 0; k < N_MODELS; k++) begin
                                    res_mu_q[k] <= (k == N_MODELS - 1) ? mu_fin : mu_q[k];
                                end
                                res_cbar_q  <= cbar_q;
                                res_norm_q  <= sat_dw(norm_q);
                                res_degen_q <= (norm_q == '0);
                            end else begin
                                j_q   <= j_inc;
                                rem_q <= RW'(w_q[j_inc]);
                                quo_q <= '0;
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_mu         = res_mu_q;
    assign out_cbar       = res_cbar_q;
    assign out_norm       = res_norm_q;
    assign out_degenerate = res_degen_q;

endmodule

// File: tb/tb_imm_mode_prob_update.sv
// Directed bench for imm_mode_prob_update with a queue-based scoreboard.
// Expected results are hand-computed per scenario and pushed on accept.
// A negedge monitor pops and compares on every output handshake.
module tb_imm_mode_prob_update;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int L  = 64;

    typedef struct packed {
        logic [N-1:0][DW-1:0] mu;
        logic [N-1:0][DW-1:0] cbar;
        logic [DW-1:0]        norm;
        logic                 degen;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, out_degenerate;
    logic [DW-1:0] in_mu_prev [N];
    logic [DW-1:0] in_pi      [N][N];
    logic [DW-1:0] in_lik     [N];
    logic [DW-1:0] out_mu     [N];
    logic [DW-1:0] out_cbar   [N];
    logic [DW-1:0] out_norm;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imm_mode_prob_update #(.N_MODELS(N), .DATA_WIDTH(DW), .FRAC_BITS(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mu_prev(in_mu_prev), .in_pi(in_pi), .in_lik(in_lik),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mu(out_mu), .out_cbar(out_cbar),
        .out_norm(out_norm), .out_degenerate(out_degenerate)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [DW-1:0] m0, m1, m2, c0, c1, c2, n,
                                input logic d);
        exp_t e;
        e.mu[0] = m0; e.mu[1] = m1; e.mu[2] = m2;
        e.cbar[0] = c0; e.cbar[1] = c1; e.cbar[2] = c2;
        e.norm = n; e.degen = d;
        return e;
    endfunction

    // Scoreboard monitor: compare every presented-and-accepted result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output out_mu0=%h with empty scoreboard", out_mu[0]);
            end else begin
                mon_e = sb.pop_front();
                for (int k = 0; k < N; k++) begin
                    chk($sformatf("mu%0d", k),   out_mu[k],   mon_e.mu[k]);
                    chk($sformatf("cbar%0d", k), out_cbar[k], mon_e.cbar[k]);
                end
                chk("norm",  out_norm, mon_e.norm);
                chk("degen", {31'd0, out_degenerate}, {31'd0, mon_e.degen});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_pi(input logic [DW-1:0] diag, input logic [DW-1:0] off);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                in_pi[i][j] = (i == j) ? diag : off;
    endtask

    task automatic set_mu(input logic [DW-1:0] a, b, c);
        in_mu_prev[0] = a; in_mu_prev[1] = b; in_mu_prev[2] = c;
    endtask

    task automatic set_lik(input logic [DW-1:0] a, b, c);
        in_lik[0] = a; in_lik[1] = b; in_lik[2] = c;
    endtask

    task automatic vec_uniform();
        set_pi(32'h10000, 32'h0);
        set_mu(32'h5555, 32'h5555, 32'h5555);
        set_lik(32'h10000, 32'h10000, 32'h10000);
    endtask

    task automatic vec_sticky(input logic [DW-1:0] lik0);
        set_pi(32'hE666, 32'h0CCC);
        set_mu(32'h10000, 32'h0, 32'h0);
        set_lik(lik0, 32'h0, 32'h0);
    endtask

    // Drive in_valid until the accept edge; push the expectation on accept.
    task automatic issue(input exp_t e, input bit push);
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) sb.push_back(e);
    endtask

    // Count cycles from accept to out_valid, bounded; check in_ready stays low.
    task automatic wait_out(input string name);
        int lat;
        logic saw_ready;
        lat = 0;
        saw_ready = 1'b0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (!out_valid && in_ready) saw_ready = 1'b1;
        end
        chk({name, "_latency"}, lat, L);
        chk({name, "_busy_in_ready"}, {31'd0, saw_ready}, 32'd0);
    endtask

    // Let the handshake happen and confirm a return to idle the next cycle.
    task automatic finish_txn(input string name);
        @(posedge clk);
        #1;
        chk({name, "_post_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_post_in_ready"},  {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_pi(32'h0, 32'h0);
        set_mu(32'h0, 32'h0, 32'h0);
        set_lik(32'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_norm",      out_norm,           32'd0);
        chk("rst_degen",     {31'd0, out_degenerate}, 32'd0);
        for (int k = 0; k < N; k++) begin
            chk("rst_mu",   out_mu[k],   32'd0);
            chk("rst_cbar", out_cbar[k], 32'd0);
        end

        // Uniform input through identity transitions.
        vec_uniform();
        issue(mk(32'h5555, 32'h5555, 32'h5555, 32'h5555, 32'h5555, 32'h5555, 32'hFFFF, 1'b0), 1'b1);
        wait_out("uniform");
        finish_txn("uniform");

        // Sticky matrix, all evidence on model 0.
        vec_sticky(32'h10000);
        issue(mk(32'h10000, 32'h0, 32'h0, 32'hE666, 32'h0CCC, 32'h0CCC, 32'hE666, 1'b0), 1'b1);
        wait_out("sticky");
        finish_txn("sticky");

        // Zero likelihoods: mu falls back to cbar.
        vec_sticky(32'h0);
        issue(mk(32'hE666, 32'h0CCC, 32'h0CCC, 32'hE666, 32'h0CCC, 32'h0CCC, 32'h0, 1'b1), 1'b1);
        wait_out("degen");
        finish_txn("degen");

        // Mixed: flat matrix, unequal likelihoods giving quarter/half/quarter.
        set_pi(32'h5555, 32'h5555);
        set_mu(32'h8000, 32'h4000, 32'h4000);
        set_lik(32'h10000, 32'h20000, 32'h10000);
        issue(mk(32'h4000, 32'h8000, 32'h4000, 32'h5554, 32'h5554, 32'h5554, 32'h15550, 1'b0), 1'b1);
        wait_out("mixed");
        finish_txn("mixed");

        // Saturating likelihood weight.
        set_pi(32'h10000, 32'h0);
        set_mu(32'h10000, 32'h0, 32'h0);
        set_lik(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(mk(32'h10000, 32'h0, 32'h0, 32'h10000, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0), 1'b1);
        wait_out("satur");
        finish_txn("satur");

        // Backpressure: hold the sticky result for 20 cycles with a new input pending.
        out_ready = 1'b0;
        vec_sticky(32'h10000);
        issue(mk(32'h10000, 32'h0, 32'h0, 32'hE666, 32'h0CCC, 32'h0CCC, 32'hE666, 1'b0), 1'b1);
        wait_out("bp");
        vec_uniform();
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
            chk("bp_mu0",       out_mu[0],          32'h10000);
            chk("bp_cbar1",     out_cbar[1],        32'h0CCC);
            chk("bp_norm",      out_norm,           32'hE666);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back(mk(32'h5555, 32'h5555, 32'h5555, 32'h5555, 32'h5555, 32'h5555, 32'hFFFF, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accepted", {31'd0, in_ready}, 32'd0);
        wait_out("bp_next");
        finish_txn("bp_next");

        // Reset during the divide phase discards the in-flight result.
        vec_sticky(32'h10000);
        issue(mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0), 1'b0);
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        vec_uniform();
        issue(mk(32'h5555, 32'h5555, 32'h5555, 32'h5555, 32'h5555, 32'h5555, 32'hFFFF, 1'b0), 1'b1);
        wait_out("midrst_next");
        finish_txn("midrst_next");

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
